// File: rtl/seq_divider_if.sv
// Operand/result bundle between the calculator operand registers and the divider.
// The divider side is the slave modport; the sequencing logic drives the master side.
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, signed_mode, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, signed_mode, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, optional two's-complement mode.
// Results and flags are registered and held until the next operation reaches DONE.
//
// state | meaning
// IDLE  | waiting for start; operands captured on accept
// CALC  | one restoring shift/subtract iteration per cycle
// FIX   | apply result signs for signed operands
// DONE  | write results and flags, pulse done
module seq_divider #(
  parameter int WIDTH     = 8,
  parameter int SIGNED_EN = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_divider_if.slave bus
);

  localparam int               CW    = $clog2(WIDTH + 1);
  localparam logic             L_SEN = (SIGNED_EN != 0);
  localparam logic [WIDTH-1:0] L_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_dvd;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div0;
  logic             r_ovf_pend;

  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dz;
  logic             r_ovf;

  logic             w_accept;
  logic             w_mode;
  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH:0]   w_a_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;

  assign w_accept  = (r_state == S_IDLE) && bus.start;
  assign w_mode    = bus.signed_mode & L_SEN;
  assign w_dvd_neg = w_mode & bus.dividend[WIDTH-1];
  assign w_dvs_neg = w_mode & bus.divisor[WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? -bus.dividend : bus.dividend;
  assign w_dvs_mag = w_dvs_neg ? -bus.divisor  : bus.divisor;

  // The extra subtractor bit keeps divisors with the MSB set from aliasing as negative.
  assign w_a_sh = {r_a, r_q[WIDTH-1]};
  assign w_diff = w_a_sh - {1'b0, r_m};
  assign w_ge   = ~w_diff[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = (bus.divisor == '0) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (r_cnt == CW'(1)) begin
          w_state_nxt = S_FIX;
        end
      end
      S_FIX:   w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_a        <= '0;
      r_q        <= '0;
      r_m        <= '0;
      r_dvd      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div0     <= 1'b0;
      r_ovf_pend <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_dz       <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_busy <= (r_state != S_IDLE) || w_accept;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_dvd      <= bus.dividend;
            r_div0     <= (bus.divisor == '0);
            r_ovf_pend <= w_mode && (bus.dividend == L_MIN) && (bus.divisor == '1);
            r_neg_q    <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r    <= w_dvd_neg;
            r_a        <= '0;
            r_q        <= w_dvd_mag;
            r_m        <= w_dvs_mag;
            r_cnt      <= CW'(WIDTH);
          end
        end
        S_CALC: begin
          r_a   <= w_ge ? w_diff[WIDTH-1:0] : {r_a[WIDTH-2:0], r_q[WIDTH-1]};
          r_q   <= {r_q[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt - CW'(1);
        end
        S_FIX: begin
          // Most-negative / -1 needs no special case: the magnitude wraps back to most-negative.
          r_q <= r_neg_q ? -r_q : r_q;
          r_a <= r_neg_r ? -r_a : r_a;
        end
        S_DONE: begin
          r_done <= 1'b1;
          if (r_div0) begin
            r_quot <= '1;
            r_rem  <= r_dvd;
            r_dz   <= 1'b1;
            r_ovf  <= 1'b0;
          end else begin
            r_quot <= r_q;
            r_rem  <= r_a;
            r_dz   <= 1'b0;
            r_ovf  <= r_ovf_pend;
          end
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_rem;
  assign bus.div_by_zero = r_dz;
  assign bus.overflow    = r_ovf;

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider: stimulus pushes expected results into per-DUT queues,
// independent monitors pop and compare whenever done pulses.
module tb_seq_divider;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
    int           lat;
    int           acc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_bad;
  exp_t exp0[$];
  exp_t exp1[$];

  seq_divider_if #(.WIDTH(W)) u_if0 ();
  seq_divider_if #(.WIDTH(W)) u_if1 ();

  seq_divider #(.WIDTH(W), .SIGNED_EN(1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(u_if0));
  seq_divider #(.WIDTH(W), .SIGNED_EN(0)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(u_if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  task automatic wait_idle(input int which);
    int n;
    n = 0;
    while (((which == 0) ? u_if0.busy : u_if1.busy) !== 1'b0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", (which == 0) ? u_if0.busy : u_if1.busy, 0);
  endtask

  task automatic issue(input int which, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                       input logic sm, input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic edz, input logic eov);
    exp_t e;
    wait_idle(which);
    if (which == 0) begin
      u_if0.start = 1'b1; u_if0.dividend = dvd; u_if0.divisor = dvs; u_if0.signed_mode = sm;
    end else begin
      u_if1.start = 1'b1; u_if1.dividend = dvd; u_if1.divisor = dvs; u_if1.signed_mode = sm;
    end
    @(posedge clk);
    #1;
    e.q   = eq;
    e.r   = er;
    e.dz  = edz;
    e.ov  = eov;
    e.lat = (dvs == '0) ? 1 : W + 2;
    e.acc = cyc;
    if (which == 0) begin
      exp0.push_back(e);
      chk("busy_after_accept0", u_if0.busy, 1);
    end else begin
      exp1.push_back(e);
      chk("busy_after_accept1", u_if1.busy, 1);
    end
    @(negedge clk);
    if (which == 0) u_if0.start = 1'b0;
    else            u_if1.start = 1'b0;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (u_if0.done === 1'b1) begin
      if (exp0.size() == 0) begin
        chk("spurious_done0", u_if0.done, 0);
      end else begin
        e = exp0.pop_front();
        chk("quotient0",  u_if0.quotient,    e.q);
        chk("remainder0", u_if0.remainder,   e.r);
        chk("div0_flag0", u_if0.div_by_zero, e.dz);
        chk("ovf_flag0",  u_if0.overflow,    e.ov);
        chk("latency0",   cyc - e.acc,       e.lat);
        chk("busy_done0", u_if0.busy,        1);
      end
    end
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (u_if1.done === 1'b1) begin
      if (exp1.size() == 0) begin
        chk("spurious_done1", u_if1.done, 0);
      end else begin
        e = exp1.pop_front();
        chk("quotient1",  u_if1.quotient,    e.q);
        chk("remainder1", u_if1.remainder,   e.r);
        chk("div0_flag1", u_if1.div_by_zero, e.dz);
        chk("ovf_flag1",  u_if1.overflow,    e.ov);
        chk("latency1",   cyc - e.acc,       e.lat);
      end
    end
  end

  initial begin
    int n;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    u_if0.start = 1'b0; u_if0.signed_mode = 1'b0; u_if0.dividend = '0; u_if0.divisor = '0;
    u_if1.start = 1'b0; u_if1.signed_mode = 1'b0; u_if1.dividend = '0; u_if1.divisor = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",      u_if0.busy,        0);
    chk("rst_done",      u_if0.done,        0);
    chk("rst_quotient",  u_if0.quotient,    0);
    chk("rst_remainder", u_if0.remainder,   0);
    chk("rst_dz",        u_if0.div_by_zero, 0);
    chk("rst_ovf",       u_if0.overflow,    0);
    rst_n = 1'b1;
    @(negedge clk);

    //          dut dividend divisor sm  quotient  remainder dz    ov
    issue(0, 8'd200, 8'd7,   1'b0, 8'd28,  8'd4,   1'b0, 1'b0);
    issue(0, 8'hF9,  8'h02,  1'b1, 8'hFD,  8'hFF,  1'b0, 1'b0);
    issue(0, 8'h07,  8'hFE,  1'b1, 8'hFD,  8'h01,  1'b0, 1'b0);
    issue(0, 8'hF9,  8'h02,  1'b0, 8'd124, 8'd1,   1'b0, 1'b0);
    issue(0, 8'h9C,  8'h07,  1'b1, 8'hF2,  8'hFE,  1'b0, 1'b0);
    issue(0, 8'h55,  8'h00,  1'b0, 8'hFF,  8'h55,  1'b1, 1'b0);
    issue(0, 8'd9,   8'd3,   1'b0, 8'd3,   8'd0,   1'b0, 1'b0);

    // Previous result must hold while the next operation computes.
    issue(0, 8'h80,  8'hFF,  1'b1, 8'h80,  8'h00,  1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("hold_quotient",  u_if0.quotient,    3);
    chk("hold_remainder", u_if0.remainder,   0);
    chk("hold_dz",        u_if0.div_by_zero, 0);

    issue(0, 8'd255, 8'd128, 1'b0, 8'd1,   8'd127, 1'b0, 1'b0);
    issue(0, 8'h80,  8'h00,  1'b1, 8'hFF,  8'h80,  1'b1, 1'b0);

    // A start pulse with new operands during CALC must be ignored.
    issue(0, 8'd100, 8'd9,   1'b0, 8'd11,  8'd1,   1'b0, 1'b0);
    repeat (2) @(negedge clk);
    u_if0.start = 1'b1; u_if0.dividend = 8'h10; u_if0.divisor = 8'h02;
    @(negedge clk);
    u_if0.start = 1'b0;

    // Reset mid-CALC: outputs clear immediately and the pending result never arrives.
    issue(0, 8'd200, 8'd7,   1'b0, 8'd28,  8'd4,   1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy",      u_if0.busy,      0);
    chk("midrst_quotient",  u_if0.quotient,  0);
    chk("midrst_remainder", u_if0.remainder, 0);
    chk("midrst_done",      u_if0.done,      0);
    exp0.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(0, 8'd250, 8'd16,  1'b0, 8'd15,  8'd10,  1'b0, 1'b0);

    // Signed mode disabled by parameter: signed_mode=1 must be ignored.
    issue(1, 8'hF9,  8'h02,  1'b1, 8'd124, 8'd1,   1'b0, 1'b0);
    issue(1, 8'h80,  8'hFF,  1'b1, 8'h00,  8'h80,  1'b0, 1'b0);

    n = 0;
    while ((exp0.size() != 0 || exp1.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk("drain_queue0", exp0.size(), 0);
    chk("drain_queue1", exp1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Parametrised multi-cycle restoring divider; successor to the calculator's fixed 4-bit combinational-loop divider.
- Computes one quotient bit per clock, with a start/busy/done handshake, an optional signed (two's-complement) mode, and divide-by-zero and overflow flags.
- Sits between the calculator operand registers and the result/display mux. Results are held until the next operation completes.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- SIGNED_EN, 1, 1 = signed_mode input honoured; 0 = signed_mode ignored, always unsigned.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- signed_mode  input  1  1 = two's-complement operands (only if SIGNED_EN=1)
- dividend  input  WIDTH  dividend, captured on accepted start
- divisor  input  WIDTH  divisor, captured on accepted start
- busy  output  1  high from the cycle after accept until done cycle inclusive
- done  output  1  one-cycle pulse; results valid from this cycle
- quotient  output  WIDTH  registered quotient
- remainder  output  WIDTH  registered remainder
- div_by_zero  output  1  registered; valid with done
- overflow  output  1  registered; valid with done

Behaviour:
- Reset (async, rst_n=0): state IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, overflow=0, internal counter/registers=0. Reset mid-operation aborts the operation; no done is issued.
- States: IDLE, CALC, FIX, DONE.
- IDLE: on clk edge with start=1, capture operands and mode (mode = signed_mode & SIGNED_EN).
  - divisor==0 -> DONE.
  - otherwise: load |dividend| and |divisor| magnitudes (abs only in signed mode), partial remainder A=0, counter=WIDTH -> CALC.
- CALC: one restoring iteration per cycle:
  - shift {A,Q} left by 1;
  - compute A-M with WIDTH+1 bits;
  - if the result is non-negative: A=result, Q[0]=1; else A is unchanged, Q[0]=0.
  - Decrement counter; when it reaches 0 -> FIX.
- FIX (1 cycle):
  - signed: negate quotient if dividend and divisor signs differ; negate remainder if dividend is negative. Truncation is toward zero; the remainder sign follows the dividend.
  - overflow=1 only for signed most-negative / -1. Quotient then wraps to most-negative, remainder=0.
  - Go to DONE.
- DONE (1 cycle): quotient, remainder and flags are written; done=1; -> IDLE.
  - Divide by zero: quotient = all ones, remainder = dividend unchanged, div_by_zero=1, overflow=0.
- Latency: start accepted at edge N; normal ops assert done at edge N+WIDTH+2; divide-by-zero asserts done at edge N+1.
- A new start may be accepted in the cycle after done (back-to-back throughput WIDTH+2 cycles).
- start while busy: ignored, no queuing. Operand changes while busy have no effect (captured copies are used).
- Outputs hold their last values between operations and during a subsequent computation until its DONE cycle. Flags are cleared/updated only at DONE.
- start held high continuously: a new operation starts each time IDLE is re-entered.
- All arithmetic is modulo 2^WIDTH on outputs. Internal subtractor width is WIDTH+1 so that an unsigned divisor with its MSB set is handled correctly.

Test Plan:
- WIDTH=8, unsigned, 200/7, start at edge N -> done pulse at N+10; quotient=28 (0x1C), remainder=4; flags 0; busy high N+1..N+10.
- Signed -7/2 (0xF9/0x02) -> quotient=0xFD (-3), remainder=0xFF (-1). Signed 7/-2 -> quotient=0xFD, remainder=0x01. Same 0xF9/0x02 with signed_mode=0 -> quotient=124, remainder=1.
- Divisor 0, dividend 0x55 -> done at N+1; quotient=0xFF, remainder=0x55, div_by_zero=1. Next op 9/3 -> quotient=3, remainder=0, div_by_zero=0.
- Signed 0x80/0xFF -> quotient=0x80, remainder=0, overflow=1. Unsigned 255/128 -> quotient=1, remainder=127, overflow=0.
- Pulse start with new operands during CALC -> ignored; first result unchanged; exactly one done.
- Drop rst_n mid-CALC -> outputs 0 immediately, no done. Start after release -> correct result with normal latency.
- SIGNED_EN=0 with signed_mode=1, 0xF9/0x02 -> unsigned result 124 r 1.
